alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, sequential successor to the 8-bit datapath ALU. It executes the same opcode set as the single-cycle unit: ADD, LSH, AND, OR, SUB, RSH and CMP. Operand width is generic, multi-bit shifts run over several cycles, and the shift/carry bit is held in an internal register that chains between operations. It sits between the register file read stage and writeback, using a valid/ready handshake on both sides so that the control FSM can stall on multi-cycle shifts.

## Interface
- W, 8: operand/result width (W ≥ 2).
- SW, $clog2(W): shift-amount width.

- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- InValid  in  1  operands and opcode are valid this cycle.
- InReady  out  1  block accepts an operation this cycle.
- DatA  in  W  operand A.
- DatB  in  W  operand B.
- ALUop  in  3  opcode: 0 ADD, 1 LSH, 2 AND, 3 OR, 4 SUB, 5 RSH, 6 CMP, 7 reserved.
- ShAmt  in  SW  shift distance for LSH/RSH; ignored for other opcodes.
- OutValid  out  1  Rslt and flags hold a completed result.
- OutReady  in  1  consumer takes the result this cycle.
- Rslt  out  W  registered result.
- Zero  out  1  registered; Rslt == 0.
- Par  out  1  registered; reduction XOR of Rslt.
- SCo  out  1  registered; current value of the internal shift/carry register (SC).

## Operation
- Accept: accept = InValid & InReady. InReady = (state == IDLE) & (!OutValid | OutReady).
- DatA, DatB, ALUop, ShAmt and the current SC are captured on accept. Inputs are don't-care afterwards.
- Single-cycle ops, evaluated at the accept edge:
  - ADD: Rslt = (A+B) mod 2^W; SC ← carry out of bit W-1.
  - SUB: Rslt = (A−B) mod 2^W; SC ← 1 iff A < B unsigned (borrow).
  - AND / OR: bitwise; SC unchanged.
  - CMP: Rslt[0] = (A ≠ B); Rslt[1] = (A > B) unsigned; the remaining bits are 0. SC unchanged.
  - Reserved opcode 7: Rslt = 0; SC unchanged.
- Shift ops (LSH/RSH) with ShAmt = 0: Rslt = A, SC unchanged, single-cycle.
- Shift ops with ShAmt = k > 0:
  - FSM goes IDLE → SHIFT. A working register is loaded with A and a down-counter with k.
  - Each SHIFT cycle shifts one bit and decrements the counter.
  - LSH fills the LSB with the SC value captured at accept, constant for the whole operation.
  - RSH fills the MSB with 0.
  - SC ← the bit shifted out, updated every step, so the final SC is the last bit out.
  - On the step where the counter reaches 0, the working register loads into Rslt, OutValid sets, and the FSM returns to IDLE.
- ShAmt ≥ W is legal; the result is all fill bits.
- Zero and Par are always computed from the value being loaded into Rslt, in the same edge.
- Output hold: while OutValid & !OutReady, Rslt, Zero, Par and SCo stay stable. No new op is accepted.
- Consume: on an edge with OutValid & OutReady and no new completion, OutValid ← 0. Rslt and flags keep their last values.
- Simultaneous consume and accept of a single-cycle op is allowed. OutValid stays 1 and Rslt updates, giving one result per cycle throughput.
- Simultaneous consume and accept of a shift with k > 0: OutValid ← 0, then sets on completion.

## Timing
- Reset values: OutValid 0, Rslt 0, Zero 0, Par 0, SCo 0, SC 0, state IDLE, counter 0. InReady is 1 in the cycle after reset deasserts.
- Latency from the accept edge to OutValid high:
  - 1 cycle for single-cycle ops and for shifts with ShAmt = 0.
  - k cycles for shifts with ShAmt = k.
- InReady is 0 throughout SHIFT and while an unconsumed result is held.
- Reset mid-SHIFT or while holding a result: everything returns to reset values at that edge and the in-flight op is discarded. Reset has priority over accept and consume in the same cycle.
- SCo reflects SC as of the last completed op. During SHIFT, SCo still shows the previous completed value; the internal SC steps, but the SCo output updates only on completion.

## Test plan
- ADD with W=8: A=0xFF, B=0x01. Require OutValid 1 cycle after accept, Rslt=0x00, Zero=1, Par=0, SCo=1.
- SUB: A=0x03, B=0x05. Require Rslt=0xFE, Zero=0, Par=1, SCo=1. A following AND of 0xF0 & 0x3C gives 0x30 with SCo still 1.
- LSH with SC=1 from the previous test: A=0x81, ShAmt=3. Require InReady=0 for 3 cycles, OutValid on the 3rd edge, Rslt=0x0F, SCo=0. Then RSH with A=0x05, ShAmt=1 gives Rslt=0x02, SCo=1.
- CMP, both single-cycle:
  - A=0x10, B=0x08 gives Rslt=0x03, Zero=0.
  - A=0x08, B=0x10 gives Rslt=0x01.
  - A=B=0x5A gives Rslt=0x00, Zero=1.
- Back-to-back ADDs with OutReady=1 and InValid held high: one result per cycle. Drop OutReady for 3 cycles: Rslt and flags stay stable, InReady=0, and no operation is lost or duplicated.
- Assert Reset during the 2nd cycle of an LSH with ShAmt=5. At the next edge require OutValid=0, Rslt=0, SCo=0 and InReady=1. No late result may appear afterwards.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: parametrised sequential ALU with multi-cycle shifts and a chained shift/carry bit
module alu_seq #(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          InValid,
  output logic          InReady,
  input  logic [W-1:0]  DatA,
  input  logic [W-1:0]  DatB,
  input  logic [2:0]    ALUop,
  input  logic [SW-1:0] ShAmt,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [W-1:0]  Rslt,
  output logic          Zero,
  output logic          Par,
  output logic          SCo
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [0:0]    state;
  logic          sc, fill, lsh, sc_n, out_bit, accept, is_sh, last;
  logic [W-1:0]  work, res, cmp, step;
  logic [SW-1:0] cnt;
  logic [W:0]    sum;
  assign InReady = (state == IDLE) & (!OutValid | OutReady);
  assign accept  = InValid & InReady;
  assign is_sh   = (ALUop == 3'd1 | ALUop == 3'd5) & (ShAmt != '0);
  assign sum     = {1'b0, DatA} + {1'b0, DatB};
  always_comb begin
    cmp    = '0;
    cmp[0] = DatA != DatB;
    cmp[1] = DatA > DatB;
  end
  // zero-distance shifts fall through here as a plain pass of A
  assign res = ALUop == 3'd0 ? sum[W-1:0] :
               ALUop == 3'd4 ? DatA - DatB :
               ALUop == 3'd2 ? DatA & DatB :
               ALUop == 3'd3 ? DatA | DatB :
               ALUop == 3'd6 ? cmp :
               (ALUop == 3'd1 | ALUop == 3'd5) ? DatA : '0;
  assign sc_n    = ALUop == 3'd0 ? sum[W] : ALUop == 3'd4 ? DatA < DatB : sc;
  assign step    = lsh ? {work[W-2:0], fill} : {1'b0, work[W-1:1]};
  assign out_bit = lsh ? work[W-1] : work[0];
  assign last    = cnt == SW'(1);
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      sc       <= 1'b0;
      fill     <= 1'b0;
      lsh      <= 1'b0;
      work     <= '0;
      cnt      <= '0;
      OutValid <= 1'b0;
      Rslt     <= '0;
      Zero     <= 1'b0;
      Par      <= 1'b0;
      SCo      <= 1'b0;
    end else if (state == SHIFT) begin
      work <= step;
      cnt  <= cnt - 1'b1;
      sc   <= out_bit;
      if (last) begin
        state    <= IDLE;
        Rslt     <= step;
        Zero     <= ~|step;
        Par      <= ^step;
        SCo      <= out_bit;
        OutValid <= 1'b1;
      end
    end else if (accept & is_sh) begin
      state    <= SHIFT;
      work     <= DatA;
      cnt      <= ShAmt;
      lsh      <= ALUop == 3'd1;
      fill     <= sc;
      OutValid <= 1'b0;
    end else if (accept) begin
      Rslt     <= res;
      Zero     <= ~|res;
      Par      <= ^res;
      sc       <= sc_n;
      SCo      <= sc_n;
      OutValid <= 1'b1;
    end else if (OutReady) begin
      OutValid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed test-plan checks plus randomized traffic against a transaction-level model
module tb_alu_seq;
  logic       Clk = 1'b0, Reset = 1'b1, InValid = 1'b0, OutReady = 1'b1;
  logic [7:0] DatA = '0, DatB = '0;
  logic [2:0] ALUop = '0, ShAmt = '0;
  logic       InReady, OutValid, Zero, Par, SCo;
  logic [7:0] Rslt;
  int tests = 0, fails = 0;
  bit chk_en = 1'b0;

  alu_seq #(.W(8)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .DatA(DatA), .DatB(DatB), .ALUop(ALUop), .ShAmt(ShAmt),
    .OutValid(OutValid), .OutReady(OutReady), .Rslt(Rslt),
    .Zero(Zero), .Par(Par), .SCo(SCo)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // arithmetic definition of each opcode; returns result, new SC, and extra edges to completion
  function automatic void model_op(input int a, input int b, input int o, input int k,
                                   input int sci, output int r, output int sc, output int lat);
    int s;
    sc  = sci;
    lat = 0;
    case (o)
      0: begin s = a + b; r = s % 256; sc = (s > 255) ? 1 : 0; end
      4: begin r = (a - b + 256) % 256; sc = (a < b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      6: r = ((a != b) ? 1 : 0) + ((a > b) ? 2 : 0);
      1: if (k == 0) r = a;
         else begin
           r = ((a << k) | (sci != 0 ? (1 << k) - 1 : 0)) & 255;
           sc = (a >> (8 - k)) & 1;
           lat = k;
         end
      5: if (k == 0) r = a;
         else begin
           r = a >> k;
           sc = (a >> (k - 1)) & 1;
           lat = k;
         end
      default: r = 0;
    endcase
  endfunction

  int m_sc = 0, m_busy = 0, m_pr = 0, m_psc = 0;
  bit m_ov = 1'b0, m_z = 1'b0, m_p = 1'b0, m_sco = 1'b0;
  logic [7:0] m_r = '0;

  always @(posedge Clk) begin
    int r, scn, lat;
    bit rdy;
    rdy = (m_busy == 0) && (!m_ov || OutReady);
    if (Reset) begin
      m_sc = 0; m_busy = 0; m_ov = 0; m_r = '0; m_z = 0; m_p = 0; m_sco = 0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_r = 8'(m_pr); m_z = (m_pr == 0); m_p = ^m_r; m_sc = m_psc; m_sco = m_psc[0]; m_ov = 1;
      end
    end else if (InValid && rdy) begin
      model_op(int'(DatA), int'(DatB), int'(ALUop), int'(ShAmt), m_sc, r, scn, lat);
      if (lat == 0) begin
        m_r = 8'(r); m_z = (r == 0); m_p = ^m_r; m_sc = scn; m_sco = scn[0]; m_ov = 1;
      end else begin
        m_busy = lat; m_pr = r; m_psc = scn; m_ov = 0;
      end
    end else if (m_ov && OutReady) m_ov = 0;
  end

  always @(negedge Clk) begin
    if (chk_en && !Reset) begin
      chk("m_inready", InReady, (m_busy == 0) && (!m_ov || OutReady));
      chk("m_outvalid", OutValid, m_ov);
      chk("m_rslt", Rslt, m_r);
      chk("m_zero", Zero, m_z);
      chk("m_par", Par, m_p);
      chk("m_sco", SCo, m_sco);
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                       input logic [2:0] k, output int lat, output int nbusy);
    int n = 0;
    bit acc;
    DatA = a; DatB = b; ALUop = o; ShAmt = k; InValid = 1'b1;
    do begin
      @(negedge Clk); acc = InReady;
      @(posedge Clk); #1; n++;
    end while (!acc && n < 50);
    InValid = 1'b0;
    if (!acc) chk("accept_timeout", 0, 1);
    lat = 0;
    nbusy = 0;
    while (!OutValid && lat < 50) begin
      @(negedge Clk); if (!InReady) nbusy++;
      @(posedge Clk); #1; lat++;
    end
    if (!OutValid) chk("result_timeout", 0, 1);
  endtask

  initial begin
    int lat, nb;
    logic [7:0] hr;
    logic hz, hp, hs;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_outvalid", OutValid, 0);
    chk("rst_rslt", Rslt, 0);
    chk("rst_zero", Zero, 0);
    chk("rst_par", Par, 0);
    chk("rst_sco", SCo, 0);
    chk("rst_inready", InReady, 1);

    issue(8'hFF, 8'h01, 3'd0, 3'd0, lat, nb);
    chk("add_extra_edges", lat, 0);
    chk("add_rslt", Rslt, 8'h00);
    chk("add_zero", Zero, 1);
    chk("add_par", Par, 0);
    chk("add_sco", SCo, 1);
    issue(8'h03, 8'h05, 3'd4, 3'd0, lat, nb);
    chk("sub_rslt", Rslt, 8'hFE);
    chk("sub_zero", Zero, 0);
    chk("sub_par", Par, 1);
    chk("sub_sco", SCo, 1);
    issue(8'hF0, 8'h3C, 3'd2, 3'd0, lat, nb);
    chk("and_rslt", Rslt, 8'h30);
    chk("and_sco", SCo, 1);
    issue(8'h81, 8'h00, 3'd1, 3'd3, lat, nb);
    chk("lsh_busy_cycles", nb, 3);
    chk("lsh_edges", lat, 3);
    chk("lsh_rslt", Rslt, 8'h0F);
    chk("lsh_sco", SCo, 0);
    issue(8'h05, 8'h00, 3'd5, 3'd1, lat, nb);
    chk("rsh_rslt", Rslt, 8'h02);
    chk("rsh_sco", SCo, 1);
    issue(8'h10, 8'h08, 3'd6, 3'd0, lat, nb);
    chk("cmp_gt_rslt", Rslt, 8'h03);
    chk("cmp_gt_zero", Zero, 0);
    issue(8'h08, 8'h10, 3'd6, 3'd0, lat, nb);
    chk("cmp_lt_rslt", Rslt, 8'h01);
    issue(8'h5A, 8'h5A, 3'd6, 3'd0, lat, nb);
    chk("cmp_eq_rslt", Rslt, 8'h00);
    chk("cmp_eq_zero", Zero, 1);

    OutReady = 1'b1; InValid = 1'b1; ALUop = 3'd0; ShAmt = '0;
    for (int i = 0; i < 6; i++) begin
      DatA = 8'($urandom); DatB = 8'($urandom);
      @(posedge Clk); #1;
      chk("b2b_valid", OutValid, 1);
    end
    OutReady = 1'b0;
    DatA = 8'($urandom); DatB = 8'($urandom);
    hr = Rslt; hz = Zero; hp = Par; hs = SCo;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      chk("hold_rslt", Rslt, hr);
      chk("hold_flags", {Zero, Par, SCo}, {hz, hp, hs});
      chk("hold_inready", InReady, 0);
    end
    OutReady = 1'b1;
    @(posedge Clk); #1;
    InValid = 1'b0;
    repeat (2) @(posedge Clk);
    #1;

    DatA = 8'($urandom); ALUop = 3'd1; ShAmt = 3'd5; InValid = 1'b1;
    @(posedge Clk); #1;
    InValid = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    chk("rstmid_outvalid", OutValid, 0);
    chk("rstmid_rslt", Rslt, 0);
    chk("rstmid_sco", SCo, 0);
    chk("rstmid_inready", InReady, 1);
    Reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); #1;
      chk("rstmid_no_late", OutValid, 0);
    end

    for (int i = 0; i < 600; i++) begin
      Reset    = ($urandom_range(0, 99) == 0);
      InValid  = ($urandom_range(0, 2) != 0);
      OutReady = ($urandom_range(0, 3) != 0);
      DatA     = 8'($urandom);
      DatB     = ($urandom_range(0, 7) == 0) ? DatA : 8'($urandom);
      ALUop    = 3'($urandom);
      ShAmt    = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom);
      @(posedge Clk); #1;
    end
    Reset = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    repeat (12) @(posedge Clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
